// File: rtl/rnd_pkg.sv
// Shared types and helpers for the random-bank sequencer.
// Provides the FSM state enum, default data width and address wrap.
package rnd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_SCAN,
        ST_HOLD
    } state_t;

    localparam int DATA_W_DEF = 16;

    // Increment an address modulo n (n need not be a power of two).
    function automatic int unsigned addr_inc(
        input int unsigned a,
        input int unsigned n
    );
        return (a + 1 >= n) ? 0 : a + 1;
    endfunction

endpackage

// File: rtl/rnd_cycle_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Ports: clk, rst (sync, active-high), load, load_val, done.
module rnd_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/rnd_bank_sequencer.sv
// Runs the random bank for a window, freezes it, XOR-folds FOLD entries.
// Ports: req valid/ready, out valid/ready/data, bank freeze/addr/data,
// busy, word_cnt (words delivered, wrapping).
module rnd_bank_sequencer
    import rnd_pkg::*;
#(
    parameter int RND_N         = 32,
    parameter int ADDR_W        = $clog2(RND_N),
    parameter int DATA_W        = DATA_W_DEF,
    parameter int RUN_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int FOLD          = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              bank_freeze,
    output logic [ADDR_W-1:0] bank_addr,
    input  logic [DATA_W-1:0] bank_data,
    output logic              busy,
    output logic [15:0]       word_cnt
);

    localparam int T_A   = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
    localparam int T_MAX = (T_A > FOLD) ? T_A : FOLD;
    localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

    localparam logic [TW-1:0] RUN_LD    = TW'(RUN_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LD =
        TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [TW-1:0] SCAN_LD   = TW'(FOLD - 1);

    state_t state, state_n;

    logic [DATA_W-1:0] acc, acc_n;
    logic [DATA_W-1:0] out_data_n;
    logic [ADDR_W-1:0] addr_n;
    logic [15:0]       word_cnt_n;
    logic              out_valid_n;
    logic              freeze_n;
    logic              first, first_n;
    logic              t_load;
    logic [TW-1:0]     t_val;
    logic              t_done;

    rnd_cycle_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bank_freeze <= 1'b1;
            bank_addr   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            acc         <= '0;
            word_cnt    <= '0;
            first       <= 1'b0;
        end else begin
            state       <= state_n;
            bank_freeze <= freeze_n;
            bank_addr   <= addr_n;
            out_valid   <= out_valid_n;
            out_data    <= out_data_n;
            acc         <= acc_n;
            word_cnt    <= word_cnt_n;
            first       <= first_n;
        end
    end

    always_comb begin
        state_n     = state;
        freeze_n    = bank_freeze;
        addr_n      = bank_addr;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        acc_n       = acc;
        word_cnt_n  = word_cnt;
        first_n     = first;
        t_load      = 1'b0;
        t_val       = '0;

        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_n  = ST_RUN;
                    freeze_n = 1'b0;
                    t_load   = 1'b1;
                    t_val    = RUN_LD;
                end
            end
            ST_RUN: begin
                if (t_done) begin
                    freeze_n = 1'b1;
                    t_load   = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state_n = ST_SCAN;
                        t_val   = SCAN_LD;
                        first_n = 1'b1;
                    end else begin
                        state_n = ST_SETTLE;
                        t_val   = SETTLE_LD;
                    end
                end
            end
            ST_SETTLE: begin
                if (t_done) begin
                    state_n = ST_SCAN;
                    t_load  = 1'b1;
                    t_val   = SCAN_LD;
                    first_n = 1'b1;
                end
            end
            ST_SCAN: begin
                // First scan cycle discards any stale accumulator.
                acc_n   = (first ? '0 : acc) ^ bank_data;
                addr_n  = ADDR_W'(addr_inc(32'(bank_addr), RND_N));
                first_n = 1'b0;
                if (t_done) begin
                    state_n     = ST_HOLD;
                    out_valid_n = 1'b1;
                    out_data_n  = acc_n;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_n     = ST_IDLE;
                    out_valid_n = 1'b0;
                    word_cnt_n  = word_cnt + 16'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state == ST_RUN) || (state == ST_SETTLE) ||
                       (state == ST_SCAN);

endmodule
